ctle_fz_ramp: RTL and testbench
===============================

Name: ctle_fz_ramp

Overview:
- Multi-lane digital controller producing the v_fz (zero-frequency) control code for NCH CTLE lanes.
- Each lane accepts a new target code, clamps it to the v_fz spec window, and slews the output toward it in bounded steps.
- Each lane holds a settle window, then reports settled. Out-of-spec requests are flagged sticky.
- Sits between the link-training/config logic and the per-lane v_fz DAC inputs of the CTLE array.

Parameters:
- NCH, 4, number of CTLE lanes
- W, 8, code width (full scale = vdd 1.8 V)
- CODE_MIN, 57, lowest in-spec code (~0.4 V)
- CODE_MAX, 199, highest in-spec code (~1.4 V)
- RST_CODE, 114, code driven after reset (~0.8 V); must lie within [CODE_MIN, CODE_MAX]
- STEP, 4, maximum code change per step, >=1
- DIV, 2, cycles between steps, >=1
- SETTLE, 8, hold cycles after reaching target, >=1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load request
- ld_ready  out  1  load can be accepted for the addressed lane
- ld_ch  in  max(1,$clog2(NCH))  lane select
- ld_code  in  W  requested target code, unclamped
- clr_oos  in  1  clear all oos flags (and violation counters)
- fz_code  out  NCH*W  current code per lane; lane i is bits [i*W +: W]
- busy  out  NCH  lane is in RAMP or SETTLE
- settled  out  NCH  lane is IDLE at target
- oos  out  NCH  sticky out-of-spec request flag
- viol_cnt  out  NCH*8  present only with FZ_VIOL_CNT_EN

Behaviour:
- Reset: every fz_code = RST_CODE, busy = 0, settled = 1, oos = 0, all lanes IDLE, divider and settle counters = 0. Reset mid-ramp aborts the ramp; all lanes return to RST_CODE on that edge.
- Per-lane FSM: IDLE -> RAMP -> SETTLE -> IDLE. busy = (RAMP|SETTLE); settled = IDLE. All outputs are registered.
- ld_ready (combinational) = 0 only when lane ld_ch is in RAMP; otherwise 1.
- ld_ch >= NCH: ld_ready = 1; an accepted load is ignored, with no state or oos change.
- Accept = ld_valid & ld_ready, one lane per cycle. On accept the target = clamp(ld_code, CODE_MIN, CODE_MAX).
- If ld_code is out of window, oos[ch] sets on the same edge.
- clr_oos clears oos. A simultaneous set on the same lane wins.
- Accept with target == current fz_code: lane goes to (or stays in) IDLE. busy stays 0.
- Accept otherwise, from IDLE or SETTLE: lane enters RAMP on that edge and the divider is cleared.
- RAMP: the divider counts 0..DIV-1. On the edge where it equals DIV-1:
  - fz_code moves toward target by min(STEP, |target - fz_code|);
  - the divider wraps to 0.
  - The first step therefore lands DIV edges after accept.
- RAMP: on the edge fz_code reaches target, the lane enters SETTLE and the settle counter is loaded.
- SETTLE: lasts exactly SETTLE cycles, then IDLE (settled = 1). A load during SETTLE restarts RAMP from the current code.
- Arithmetic: the step math uses W+1 bits. No wrap below 0 or above 2^W-1 is possible because the target is clamped.
- Lanes are fully independent. A load to one lane never disturbs another lane's ramp.

Optional Feature:
- Macro FZ_VIOL_CNT_EN.
- Defined: the viol_cnt port exists. Each lane has an 8-bit counter that increments on every accepted out-of-window load for that lane and saturates at 255. clr_oos clears it; a simultaneous increment is dropped.
- Undefined: no counters and no viol_cnt port. oos behaviour is unchanged.

Test Plan:
- Reset -> all fz_code = 114, settled = 4'hF, busy = 0, oos = 0, ld_ready = 1.
- Load lane0 code 130, accepted at edge 0 -> fz_code[0] takes 118/122/126/130 at edges 2/4/6/8; busy = 1 throughout; settled[0] = 1 after edge 16; lanes 1-3 stay at 114.
- Load lane1 code 13 (below window) -> target 57, oos[1] = 1 from edge 0. Ramp is 114→110…→58→57 with a final step of 1. Pulse clr_oos -> oos[1] = 0 (viol_cnt[1] = 1 before the clear when FZ_VIOL_CNT_EN).
- Load lane2 code 240 (above window) -> clamps to 199, oos[2] = 1. While lane2 is in RAMP, ld_ready = 0 for ld_ch = 2 and 1 for ld_ch = 3. A lane3 load of 100 is accepted and both lanes ramp concurrently.
- Load lane0 code 114 while IDLE at 114 -> no busy pulse, settled stays 1. Load 150 then, during SETTLE, load 140 -> RAMP restarts downward from 150.
- Assert rst mid-ramp on lane2 -> next edge fz_code[2] = 114, busy = 0, oos = 0. With FZ_VIOL_CNT_EN, 300 out-of-window loads -> viol_cnt saturates at 255.

Source files
------------

// File: rtl/ctle_fz_ramp.sv
// Multi-lane v_fz control-code generator: clamps each lane's requested code to the
// spec window, slews toward it in bounded steps, then holds a settle window.
// Optional build macro FZ_VIOL_CNT_EN adds per-lane 8-bit out-of-window load counters (viol_cnt).
module ctle_fz_ramp #(
  parameter int NCH      = 4,
  parameter int W        = 8,
  parameter int CODE_MIN = 57,
  parameter int CODE_MAX = 199,
  parameter int RST_CODE = 114,
  parameter int STEP     = 4,
  parameter int DIV      = 2,
  parameter int SETTLE   = 8,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [CW-1:0]    ld_ch,
  input  logic [W-1:0]     ld_code,
  input  logic             clr_oos,
  output logic [NCH*W-1:0] fz_code,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   settled,
`ifdef FZ_VIOL_CNT_EN
  output logic [NCH*8-1:0] viol_cnt,
`endif
  output logic [NCH-1:0]   oos
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE} state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [W-1:0]   code_q  [NCH];
  logic [W-1:0]   code_d  [NCH];
  logic [W-1:0]   tgt_q   [NCH];
  logic [W-1:0]   tgt_d   [NCH];
  logic [DW-1:0]  div_q   [NCH];
  logic [DW-1:0]  div_d   [NCH];
  logic [SW-1:0]  set_q   [NCH];
  logic [SW-1:0]  set_d   [NCH];
  logic [NCH-1:0] oos_q, oos_d;
`ifdef FZ_VIOL_CNT_EN
  logic [7:0]     vcnt_q  [NCH];
  logic [7:0]     vcnt_d  [NCH];
`endif

  logic         in_win;
  logic [W-1:0] clamped;
  logic         accept;

  always_comb begin
    in_win  = 1'b1;
    clamped = ld_code;
    if (ld_code < W'(CODE_MIN)) begin
      in_win  = 1'b0;
      clamped = W'(CODE_MIN);
    end else if (ld_code > W'(CODE_MAX)) begin
      in_win  = 1'b0;
      clamped = W'(CODE_MAX);
    end
  end

  // Lane selects that match no lane leave ld_ready high and the load falls on the floor.
  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (ld_ch == CW'(i) && state_q[i] == S_RAMP) ld_ready = 1'b0;
  end

  assign accept = ld_valid & ld_ready;

  // NOTE: every next-state variable gets its default first so no path infers a latch.
  always_comb begin
    logic         hit, up;
    logic [W:0]   diff, stp, nxt;
    oos_d = oos_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      code_d[i]  = code_q[i];
      tgt_d[i]   = tgt_q[i];
      div_d[i]   = div_q[i];
      set_d[i]   = set_q[i];
`ifdef FZ_VIOL_CNT_EN
      vcnt_d[i]  = vcnt_q[i];
`endif
      hit  = accept && (ld_ch == CW'(i));
      up   = tgt_q[i] > code_q[i];
      diff = up ? ({1'b0, tgt_q[i]} - {1'b0, code_q[i]})
                : ({1'b0, code_q[i]} - {1'b0, tgt_q[i]});
      stp  = (diff > (W+1)'(STEP)) ? (W+1)'(STEP) : diff;
      nxt  = up ? ({1'b0, code_q[i]} + stp) : ({1'b0, code_q[i]} - stp);

      case (state_q[i])
        S_RAMP: begin
          if (div_q[i] == DW'(DIV - 1)) begin
            code_d[i] = nxt[W-1:0];
            div_d[i]  = '0;
            if (nxt[W-1:0] == tgt_q[i]) begin
              state_d[i] = S_SETTLE;
              set_d[i]   = SW'(SETTLE - 1);
            end
          end else begin
            div_d[i] = div_q[i] + 1'b1;
          end
        end
        S_SETTLE: begin
          if (set_q[i] == '0) state_d[i] = S_IDLE;
          else                set_d[i]   = set_q[i] - 1'b1;
        end
        default: ;
      endcase

      // A hit can only occur outside RAMP, so it simply overrides the lane's progress.
      if (hit) begin
        tgt_d[i] = clamped;
        if (clamped == code_q[i]) begin
          state_d[i] = S_IDLE;
        end else begin
          state_d[i] = S_RAMP;
          div_d[i]   = '0;
        end
      end

      if (clr_oos)         oos_d[i] = 1'b0;
      if (hit && !in_win)  oos_d[i] = 1'b1;
`ifdef FZ_VIOL_CNT_EN
      if (clr_oos)                                 vcnt_d[i] = '0;
      else if (hit && !in_win && vcnt_q[i] != 8'hFF) vcnt_d[i] = vcnt_q[i] + 1'b1;
`endif
    end
  end

  // NOTE: state uses non-blocking assignments; every per-lane register array is reset
  // because each entry is live control state, not bulk storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      oos_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        code_q[i]  <= W'(RST_CODE);
        tgt_q[i]   <= W'(RST_CODE);
        div_q[i]   <= '0;
        set_q[i]   <= '0;
`ifdef FZ_VIOL_CNT_EN
        vcnt_q[i]  <= '0;
`endif
      end
    end else begin
      oos_q <= oos_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        code_q[i]  <= code_d[i];
        tgt_q[i]   <= tgt_d[i];
        div_q[i]   <= div_d[i];
        set_q[i]   <= set_d[i];
`ifdef FZ_VIOL_CNT_EN
        vcnt_q[i]  <= vcnt_d[i];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      fz_code[i*W +: W] = code_q[i];
      busy[i]           = (state_q[i] != S_IDLE);
      settled[i]        = (state_q[i] == S_IDLE);
`ifdef FZ_VIOL_CNT_EN
      viol_cnt[i*8 +: 8] = vcnt_q[i];
`endif
    end
  end

  assign oos = oos_q;

endmodule

// File: tb/tb_ctle_fz_ramp.sv
// Scoreboard bench for ctle_fz_ramp: a trajectory-based lane model predicts the
// outputs after each edge; a negedge monitor pops and compares them.
module tb_ctle_fz_ramp;
  localparam int NCH = 4, W = 8, CODE_MIN = 57, CODE_MAX = 199, RST_CODE = 114;
  localparam int STEP = 4, DIV = 2, SETTLE = 8;
  localparam int CW = 2;
  localparam int BIG = 1 << 20;

  logic             clk = 1'b0;
  logic             rst, ld_valid, ld_ready, clr_oos;
  logic [CW-1:0]    ld_ch;
  logic [W-1:0]     ld_code;
  logic [NCH*W-1:0] fz_code;
  logic [NCH-1:0]   busy, settled, oos;
`ifdef FZ_VIOL_CNT_EN
  logic [NCH*8-1:0] viol_cnt;
`endif

  ctle_fz_ramp dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch),
    .ld_code(ld_code), .clr_oos(clr_oos), .fz_code(fz_code), .busy(busy),
    .settled(settled),
`ifdef FZ_VIOL_CNT_EN
    .viol_cnt(viol_cnt),
`endif
    .oos(oos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*W-1:0] code;
    logic [NCH-1:0]   busy, settled, oos;
    logic [NCH*8-1:0] vc;
  } exp_t;

  exp_t sbq[$];
  int tests = 0, fails = 0;

  // Lane model: a ramp is described by its start code, target and edges elapsed since accept.
  int m_start[NCH], m_tgt[NCH], m_age[NCH], m_vc[NCH];
  bit m_oos[NCH];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_dist(int l);
    return (m_tgt[l] > m_start[l]) ? m_tgt[l] - m_start[l] : m_start[l] - m_tgt[l];
  endfunction

  function automatic int m_ramp_len(int l);
    return ((m_dist(l) + STEP - 1) / STEP) * DIV;
  endfunction

  function automatic int m_code(int l);
    int moved = STEP * (m_age[l] / DIV);
    if (moved > m_dist(l)) moved = m_dist(l);
    return (m_tgt[l] >= m_start[l]) ? m_start[l] + moved : m_start[l] - moved;
  endfunction

  function automatic bit m_in_ramp(int l);
    return m_age[l] < m_ramp_len(l);
  endfunction

  function automatic bit m_busy(int l);
    return m_age[l] < m_ramp_len(l) + SETTLE;
  endfunction

  // Checks ld_ready before the edge, advances the model across the edge, queues the expectation.
  task automatic tick();
    int ch, code, tgt, cur;
    bit rdy, acc, bad;
    exp_t e;
    #1;
    ch  = int'(ld_ch);
    rdy = (ch >= NCH) ? 1'b1 : !m_in_ramp(ch);
    if (!rst) check("ld_ready", ld_ready, rdy);
    if (rst) begin
      for (int l = 0; l < NCH; l++) begin
        m_start[l] = RST_CODE; m_tgt[l] = RST_CODE; m_age[l] = BIG;
        m_oos[l] = 0; m_vc[l] = 0;
      end
    end else begin
      acc  = ld_valid && rdy && ch < NCH;
      code = int'(ld_code);
      bad  = code < CODE_MIN || code > CODE_MAX;
      tgt  = code < CODE_MIN ? CODE_MIN : (code > CODE_MAX ? CODE_MAX : code);
      cur  = acc ? m_code(ch) : 0;
      for (int l = 0; l < NCH; l++) if (m_age[l] < BIG) m_age[l]++;
      if (clr_oos) for (int l = 0; l < NCH; l++) begin m_oos[l] = 0; m_vc[l] = 0; end
      if (acc) begin
        m_start[ch] = cur;
        m_tgt[ch]   = tgt;
        m_age[ch]   = (tgt == cur) ? BIG : 0;
        if (bad) begin
          m_oos[ch] = 1;
          if (!clr_oos && m_vc[ch] < 255) m_vc[ch]++;
        end
      end
    end
    for (int l = 0; l < NCH; l++) begin
      e.code[l*W +: W] = W'(m_code(l));
      e.busy[l]        = m_busy(l);
      e.settled[l]     = !m_busy(l);
      e.oos[l]         = m_oos[l];
      e.vc[l*8 +: 8]   = 8'(m_vc[l]);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit v, int ch, int code, bit clr);
    rst = r; ld_valid = v; ld_ch = CW'(ch); ld_code = W'(code); clr_oos = clr;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("fz_code", fz_code, e.code);
        check("busy", busy, e.busy);
        check("settled", settled, e.settled);
        check("oos", oos, e.oos);
`ifdef FZ_VIOL_CNT_EN
        check("viol_cnt", viol_cnt, e.vc);
`endif
      end
    end
  end

  initial begin : stim
    int waited;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(2);
    // lane0 up-ramp to 130, other lanes untouched
    drive(0, 1, 0, 130, 0);
    idle(20);
    // lane1 below window: clamp to 57, final step of 1, then clear oos
    drive(0, 1, 1, 13, 0);
    idle(40);
    drive(0, 0, 0, 0, 1);
    idle(2);
    // lane2 above window; retry on lane2 is refused while lane3 load proceeds
    drive(0, 1, 2, 240, 0);
    drive(0, 1, 2, 50, 0);
    drive(0, 1, 3, 100, 0);
    idle(50);
    // lane0 back to 114, re-load equal code, then restart from SETTLE
    drive(0, 1, 0, 114, 0);
    idle(20);
    drive(0, 1, 0, 114, 0);
    idle(3);
    drive(0, 1, 0, 150, 0);
    idle(20);
    drive(0, 1, 0, 140, 0);
    idle(25);
    // reset mid-ramp on lane2
    drive(0, 1, 2, 57, 0);
    idle(5);
    drive(1, 0, 0, 0, 0);
    idle(2);
    // many out-of-window loads to lane1 (counter saturation when enabled)
    for (int i = 0; i < 340; i++) drive(0, 1, 1, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, NCH - 1), $urandom_range(0, 255),
            $urandom_range(0, 39) == 0);
    idle(3);
    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
